push_debounce: RTL
==================

// Module: push_debounce
// PURPOSE
//   Front-end conditioning stage for the push-button inputs feeding the LED
//   up/down Counter. Synchronises raw active-low buttons to Clk, debounces
//   each one independently, and emits a debounced level plus a single-cycle
//   press pulse per button. Counter consumes Pulse_o as its step commands.
// PARAMETERS
//   N_BTN       2        number of buttons (bit1 = up, bit0 = down on the board)
//   DEB_CYCLES  1000000  consecutive stable cycles needed to accept a change; >= 2
//   CNT_W       20       debounce counter width; 2**CNT_W > DEB_CYCLES
// PORTS
//   Clk      in   1      system clock, rising edge
//   Rst      in   1      asynchronous reset, active-high
//   Push_i   in   N_BTN  raw buttons, active-low (1 = released), asynchronous
//   Level_o  out  N_BTN  debounced state, active-high (1 = held)
//   Pulse_o  out  N_BTN  one-Clk pulse on each accepted press, active-high
// BEHAVIOUR
//   Reset (async assert, sync release): sync flops = 1 (released), all FSMs
//     REL, counters 0, Level_o = 0, Pulse_o = 0.
//   Sync: per bit two flops s1 <= Push_i, s2 <= s1. FSM uses only s2;
//     p = ~s2 (pressed).
//   Per-button FSM, all bits independent, no shared state:
//     REL     : Level=0. p=1 -> REL_CHK, cnt<=1. else stay, cnt<=0.
//     REL_CHK : p=0 -> REL, cnt<=0 (glitch rejected, no pulse).
//               p=1 & cnt==DEB_CYCLES-1 -> PRS, cnt<=0, Pulse<=1 (one cycle).
//               p=1 otherwise -> cnt<=cnt+1.
//     PRS     : Level=1. p=0 -> PRS_CHK, cnt<=1. else stay.
//     PRS_CHK : p=1 -> PRS, cnt<=0. p=0 & cnt==DEB_CYCLES-1 -> REL, cnt<=0.
//               p=0 otherwise -> cnt<=cnt+1. No pulse on release.
//   Level_o and Pulse_o are registered; Level_o rises on the same edge
//     Pulse_o rises, falls on entry to REL.
//   Latency: first edge sampling Push_i low = k; Pulse_o/Level_o high after
//     edge k+1+DEB_CYCLES (DEB_CYCLES consecutive pressed s2 samples).
//   Release latency identical (k+1+DEB_CYCLES after first high sample).
//   Pulse_o is high exactly one cycle per accepted press regardless of hold
//     length; no auto-repeat.
//   Bounce: any return to the stable value in a CHK state restarts the count
//     from 0; counter never exceeds DEB_CYCLES-1, never wraps.
//   Simultaneous: both buttons may pulse in the same cycle; arbitration is
//     the Counter's responsibility, not this block's.
//   Reset mid-operation: all state discarded immediately, pulse in flight
//     dropped. A button still held at reset release is treated as a new
//     press and produces one pulse after the normal latency.
// TESTING  (bench: 20 ns Clk, DEB_CYCLES=4, CNT_W=3, Push_i idle 2'b11)
//   Reset: Rst=1 with Push_i=2'b00 -> Level_o=0, Pulse_o=0 while Rst high;
//     after release, one pulse on both bits 5 cycles later, Level_o=2'b11.
//   Clean press: Push_i=2'b01 for 200 ns then 2'b11 -> Pulse_o=2'b10 for
//     exactly 1 cycle, 5 cycles after press; Level_o[1] high ~10 cycles.
//   Bounce: Push_i bit0 low 3 cycles, high 1, low 3 -> no pulse; then low
//     8 cycles -> exactly one Pulse_o[0].
//   Repeat: 13 cycles of 2'b01/2'b11 at 200 ns each -> 13 pulses on bit1,
//     none on bit0; 11 cycles of 2'b10/2'b11 -> 11 pulses on bit0.
//   Simultaneous: Push_i 2'b11 -> 2'b00 at one edge -> Pulse_o=2'b11 same cycle.
//   Reset mid-check: Rst pulsed while in REL_CHK (cnt=2) -> no pulse, Level_o=0.

Source files
------------

// File: rtl/push_debounce.sv
// Push-button conditioning: two-flop synchroniser, per-button debounce FSM,
// registered debounced level and a single-cycle pulse on each accepted press.
// Buttons are active-low at the pins. Level_o and Pulse_o are active-high.
module push_debounce #(
  parameter int N_BTN      = 2,
  parameter int DEB_CYCLES = 1000000,
  parameter int CNT_W      = 20
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [N_BTN-1:0] Push_i,
  output logic [N_BTN-1:0] Level_o,
  output logic [N_BTN-1:0] Pulse_o
);

  // REL/PRS are the stable states. The *_CHK states count consecutive samples
  // of the opposite value before the change is accepted.
  typedef enum logic [1:0] {
    REL     = 2'd0,
    REL_CHK = 2'd1,
    PRS     = 2'd2,
    PRS_CHK = 2'd3
  } state_e;

  // The counter is reloaded with 1 on entry to a CHK state. The change is
  // accepted when it reaches DEB_CYCLES-1 and one more matching sample arrives.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Synchroniser stages. Reset to the released level (1).
  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync2_q;
  logic [N_BTN-1:0] pressed;

  // Per-button FSM state and debounce counter.
  state_e           state_q [N_BTN];
  state_e           state_d [N_BTN];
  logic [CNT_W-1:0] cnt_q   [N_BTN];
  logic [CNT_W-1:0] cnt_d   [N_BTN];

  // Registered outputs.
  logic [N_BTN-1:0] level_q;
  logic [N_BTN-1:0] level_d;
  logic [N_BTN-1:0] pulse_q;
  logic [N_BTN-1:0] pulse_d;

  // Counter increment that saturates at the acceptance value. The FSM never
  // asks for more than that, so the counter cannot wrap.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    if (c >= CNT_LAST) begin
      return CNT_LAST;
    end
    return c + CNT_ONE;
  endfunction

  // Two-flop synchroniser for the asynchronous raw button pins.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= Push_i;
      sync2_q <= sync1_q;
    end
  end

  // The FSM works in the pressed domain: 1 means the button is held.
  assign pressed = ~sync2_q;

  // State register: FSM state, counters and registered outputs for every button.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= REL;
        cnt_q[i]   <= '0;
      end
      level_q <= '0;
      pulse_q <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  // Next-state logic. Each button is evaluated independently, with no shared terms.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        REL: begin
          if (pressed[i]) begin
            state_d[i] = REL_CHK;
            cnt_d[i]   = CNT_ONE;
          end else begin
            cnt_d[i]   = '0;
          end
        end
        REL_CHK: begin
          if (!pressed[i]) begin
            // Bounce back to released. Reject the change and restart later.
            state_d[i] = REL;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = PRS;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i]   = cnt_inc(cnt_q[i]);
          end
        end
        PRS: begin
          if (!pressed[i]) begin
            state_d[i] = PRS_CHK;
            cnt_d[i]   = CNT_ONE;
          end else begin
            cnt_d[i]   = '0;
          end
        end
        PRS_CHK: begin
          if (pressed[i]) begin
            // Bounce back to held. The button stays pressed.
            state_d[i] = PRS;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = REL;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i]   = cnt_inc(cnt_q[i]);
          end
        end
        default: begin
          state_d[i] = REL;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Output decode from the next state, so the registered level rises together
  // with the pulse and falls on the edge that enters REL.
  always_comb begin
    level_d = '0;
    pulse_d = '0;
    for (int i = 0; i < N_BTN; i++) begin
      level_d[i] = (state_d[i] == PRS) || (state_d[i] == PRS_CHK);
      pulse_d[i] = (state_q[i] == REL_CHK) && (state_d[i] == PRS);
    end
  end

  assign Level_o = level_q;
  assign Pulse_o = pulse_q;

endmodule
